// File: rtl/pipe_operand_loader.sv
// Operand collector for the 3-stage arithmetic pipe: gathers a,b,c,d from a
// narrow stream, issues them as one registered set and flags the matching result.
module pipe_operand_loader #(
  parameter int N   = 10,
  parameter int LAT = 3,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [N-1:0]  a,
  output logic [N-1:0]  b,
  output logic [N-1:0]  c,
  output logic [N-1:0]  d,
  output logic          issue,
  output logic          res_valid,
  output logic [CW-1:0] set_count,
  output logic          busy
);

  typedef enum logic [2:0] {
    COL_A,
    COL_B,
    COL_C,
    COL_D,
    ISSUE
  } state_t;

  state_t         state;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   sc;
  logic [LAT-1:0] sr;
  logic           accept;

  assign in_ready  = (state != ISSUE) && !flush;
  assign accept    = in_valid && in_ready;
  assign issue     = (state == ISSUE);
  assign busy      = (state != COL_A);
  assign res_valid = sr[LAT-1];

  // sr carries one token per issued set, timed to the pipe latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= issue;
      for (int i = 1; i < LAT; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COL_A;
      sa        <= '0;
      sb        <= '0;
      sc        <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      set_count <= '0;
    end else if (flush && state != ISSUE) begin
      state <= COL_A;
    end else begin
      unique case (state)
        COL_A: begin
          if (accept) begin
            sa    <= in_data;
            state <= COL_B;
          end
        end
        COL_B: begin
          if (accept) begin
            sb    <= in_data;
            state <= COL_C;
          end
        end
        COL_C: begin
          if (accept) begin
            sc    <= in_data;
            state <= COL_D;
          end
        end
        COL_D: begin
          if (accept) begin
            a     <= sa;
            b     <= sb;
            c     <= sc;
            d     <= in_data;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          set_count <= set_count + 1'b1;
          state     <= COL_A;
        end
        default: state <= COL_A;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_operand_loader.sv
// Directed bench for pipe_operand_loader with a behavioural model of the
// downstream 3-stage pipe f = ((a+b)+(c-d))*d.
module tb_pipe_operand_loader;
  localparam int N   = 10;
  localparam int LAT = 3;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst2;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          flush;
  logic          in_ready;
  logic [N-1:0]  a, b, c, d;
  logic          issue;
  logic          res_valid;
  logic [CW-1:0] set_count;
  logic          busy;

  logic          in_ready2;
  logic [N-1:0]  a2, b2, c2, d2;
  logic          issue2;
  logic          res_valid2;
  logic [1:0]    set_count2;
  logic          busy2;

  logic [N-1:0]  p_s1, p_t1, p_d1, p_s2, p_d2, f;

  int tests = 0;
  int fails = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  pipe_operand_loader #(.N(N), .LAT(LAT), .CW(CW)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .a(a), .b(b), .c(c), .d(d),
    .issue(issue), .res_valid(res_valid), .set_count(set_count),
    .busy(busy)
  );

  pipe_operand_loader #(.N(N), .LAT(LAT), .CW(2)) u2 (
    .clk(clk), .rst(rst2), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .flush(flush), .a(a2), .b(b2), .c(c2), .d(d2),
    .issue(issue2), .res_valid(res_valid2), .set_count(set_count2),
    .busy(busy2)
  );

  // downstream pipe model, no reset
  always_ff @(posedge clk) begin
    p_s1 <= a + b;
    p_t1 <= c - d;
    p_d1 <= d;
    p_s2 <= p_s1 + p_t1;
    p_d2 <= p_d1;
    f    <= p_s2 * p_d2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_set(input logic [N-1:0] w0, input logic [N-1:0] w1,
                          input logic [N-1:0] w2, input logic [N-1:0] w3);
    logic [N-1:0] w[4];
    int idx = 0;
    int guard = 0;
    logic acc;
    w = '{w0, w1, w2, w3};
    while (idx < 4 && guard < 20) begin
      in_valid = 1'b1;
      in_data  = w[idx];
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    tests++;
    if (idx != 4) begin
      fails++;
      $display("FAIL send_set: accepted %0d words, required 4", idx);
    end
  endtask

  task automatic wait_res(output int cyc, output logic [N-1:0] fv);
    cyc = 0;
    while (!res_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    fv = f;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    in_valid = 1'b0; in_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({a, b, c, d} !== '0 || issue !== 1'b0 || res_valid !== 1'b0 ||
        set_count !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: a=%0d b=%0d c=%0d d=%0d issue=%b rv=%b cnt=%0d busy=%b, required all 0",
               a, b, c, d, issue, res_valid, set_count, busy);
    end
    rst = 1'b0; rst2 = 1'b0;
    tick();
  endtask

  task automatic test_single;
    logic [N-1:0] w[4];
    int cyc;
    logic [N-1:0] fv;
    w = '{10'd2, 10'd3, 10'd9, 10'd5};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = w[i];
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL t1_ready word %0d: got %b required 1", i, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tests++;
    if (issue !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL t1_issue: issue=%b in_ready=%b required 1/0", issue, in_ready);
    end
    tests++;
    if (a !== 10'd2 || b !== 10'd3 || c !== 10'd9 || d !== 10'd5) begin
      fails++;
      $display("FAIL t1_ops: %0d %0d %0d %0d required 2 3 9 5", a, b, c, d);
    end
    exp_count = 1;
    wait_res(cyc, fv);
    tests++;
    if (cyc != 3 || fv !== 10'd45) begin
      fails++;
      $display("FAIL t1_result: delay=%0d f=%0d required 3/45", cyc, fv);
    end
    tests++;
    if (set_count !== CW'(exp_count)) begin
      fails++;
      $display("FAIL t1_count: got %0d required %0d", set_count, exp_count);
    end
    tick();
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL t1_rv_pulse: got %b required 0", res_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] w[8];
    int idx = 0;
    logic acc;
    logic iss_cyc;
    logic rv_cyc;
    w = '{10'd1, 10'd1, 10'd1, 10'd1, 10'd1023, 10'd1, 10'd0, 10'd1};
    for (int k = 0; k < 14; k++) begin
      in_valid = (idx < 8);
      in_data  = (idx < 8) ? w[idx] : '0;
      #1;
      iss_cyc = (k == 4 || k == 9);
      rv_cyc  = (k == 7 || k == 12);
      tests++;
      if (in_ready !== !iss_cyc || issue !== iss_cyc) begin
        fails++;
        $display("FAIL t2_cycle %0d: in_ready=%b issue=%b required %b/%b",
                 k, in_ready, issue, !iss_cyc, iss_cyc);
      end
      tests++;
      if (res_valid !== rv_cyc) begin
        fails++;
        $display("FAIL t2_rv cycle %0d: got %b required %b", k, res_valid, rv_cyc);
      end
      if (rv_cyc) begin
        tests++;
        if (f !== ((k == 7) ? 10'd2 : 10'd1023)) begin
          fails++;
          $display("FAIL t2_f cycle %0d: got %0d required %0d",
                   k, f, (k == 7) ? 2 : 1023);
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    exp_count = 3;
    tests++;
    if (set_count !== CW'(exp_count)) begin
      fails++;
      $display("FAIL t2_count: got %0d required %0d", set_count, exp_count);
    end
  endtask

  task automatic test_gaps;
    logic [N-1:0] w[4];
    int gap;
    int cyc;
    logic [N-1:0] fv;
    w = '{10'd2, 10'd3, 10'd9, 10'd5};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      @(posedge clk);
      #1;
      if (i < 3) begin
        gap = (i == 1) ? 1 : int'($urandom_range(1, 2));
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_data  = 10'd77;
          #1;
          tests++;
          if (busy !== 1'b1 || issue !== 1'b0 || a !== 10'd1023 || d !== 10'd1) begin
            fails++;
            $display("FAIL t3_gap after %0d: busy=%b issue=%b a=%0d d=%0d required 1/0/1023/1",
                     i, busy, issue, a, d);
          end
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
    tests++;
    if (issue !== 1'b1 || a !== 10'd2 || b !== 10'd3 || c !== 10'd9 || d !== 10'd5) begin
      fails++;
      $display("FAIL t3_issue: issue=%b ops %0d %0d %0d %0d required 1 2 3 9 5",
               issue, a, b, c, d);
    end
    exp_count = 4;
    wait_res(cyc, fv);
    tests++;
    if (cyc != 3 || fv !== 10'd45) begin
      fails++;
      $display("FAIL t3_result: delay=%0d f=%0d required 3/45", cyc, fv);
    end
  endtask

  task automatic test_flush;
    logic [N-1:0] w[4];
    w = '{10'd2, 10'd3, 10'd9, 10'd5};
    in_valid = 1'b1;
    in_data = 10'd7;
    tick();
    in_data = 10'd8;
    tick();
    in_data = 10'd99;
    flush = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL t4_flush_ready: got %b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || a !== 10'd2 || d !== 10'd5) begin
      fails++;
      $display("FAIL t4_after_flush: busy=%b a=%0d d=%0d required 0/2/5", busy, a, d);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      #1;
      tests++;
      if (issue !== 1'b0) begin
        fails++;
        $display("FAIL t4_early_issue word %0d: got %b required 0", i, issue);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    tests++;
    if (issue !== 1'b1 || a !== 10'd2 || b !== 10'd3 || c !== 10'd9 || d !== 10'd5) begin
      fails++;
      $display("FAIL t4_issue: issue=%b ops %0d %0d %0d %0d required 1 2 3 9 5",
               issue, a, b, c, d);
    end
    exp_count = 5;
    tick();
    tests++;
    if (set_count !== CW'(exp_count)) begin
      fails++;
      $display("FAIL t4_count: got %0d required %0d", set_count, exp_count);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [N-1:0] fv;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = N'(i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || issue !== 1'b0 ||
        {a, b, c, d} !== '0 || set_count !== '0 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL t5_async_rst: busy=%b rdy=%b issue=%b a=%0d d=%0d cnt=%0d rv=%b required 0/1/0/0/0/0/0",
               busy, in_ready, issue, a, d, set_count, res_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_count = 0;
    send_set(10'd4, 10'd6, 10'd1, 10'd2);
    tests++;
    if (issue !== 1'b1 || a !== 10'd4 || d !== 10'd2) begin
      fails++;
      $display("FAIL t5_pre_issue: issue=%b a=%0d d=%0d required 1/4/2", issue, a, d);
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (res_valid !== 1'b0 || a !== '0 || d !== '0 || set_count !== '0) begin
      fails++;
      $display("FAIL t5_rst_after_issue: rv=%b a=%0d d=%0d cnt=%0d required 0",
               res_valid, a, d, set_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (res_valid !== 1'b0) begin
        fails++;
        $display("FAIL t5_stale_token cycle %0d: got %b required 0", k, res_valid);
      end
      tick();
    end
    send_set(10'd2, 10'd3, 10'd9, 10'd5);
    tests++;
    if (issue !== 1'b1 || a !== 10'd2 || b !== 10'd3 || c !== 10'd9 || d !== 10'd5) begin
      fails++;
      $display("FAIL t5_post_issue: issue=%b ops %0d %0d %0d %0d required 1 2 3 9 5",
               issue, a, b, c, d);
    end
    exp_count = 1;
    wait_res(cyc, fv);
    tests++;
    if (cyc != 3 || fv !== 10'd45 || set_count !== CW'(exp_count)) begin
      fails++;
      $display("FAIL t5_post_result: delay=%0d f=%0d cnt=%0d required 3/45/1",
               cyc, fv, set_count);
    end
    tick();
  endtask

  task automatic test_count_wrap;
    logic [N-1:0] s[4][4];
    logic [1:0] ec;
    s = '{'{10'd1, 10'd2, 10'd3, 10'd4}, '{10'd5, 10'd6, 10'd7, 10'd8},
          '{10'd10, 10'd20, 10'd30, 10'd40}, '{10'd100, 10'd200, 10'd300, 10'd400}};
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    tests++;
    if (set_count2 !== 2'd0) begin
      fails++;
      $display("FAIL t6_count_init: got %0d required 0", set_count2);
    end
    for (int k = 0; k < 4; k++) begin
      send_set(s[k][0], s[k][1], s[k][2], s[k][3]);
      tests++;
      if (issue2 !== 1'b1) begin
        fails++;
        $display("FAIL t6_issue set %0d: got %b required 1", k, issue2);
      end
      tick();
      ec = 2'(k + 1);
      tests++;
      if (set_count2 !== ec) begin
        fails++;
        $display("FAIL t6_count set %0d: got %0d required %0d", k, set_count2, ec);
      end
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = N'(11 + i);
      tick();
      tests++;
      if (a2 !== 10'd100 || b2 !== 10'd200 || c2 !== 10'd300 || d2 !== 10'd400) begin
        fails++;
        $display("FAIL t6_hold word %0d: ops %0d %0d %0d %0d required 100 200 300 400",
                 i, a2, b2, c2, d2);
      end
    end
    in_data = 10'd14;
    tick();
    in_valid = 1'b0;
    tests++;
    if (issue2 !== 1'b1 || a2 !== 10'd11 || d2 !== 10'd14) begin
      fails++;
      $display("FAIL t6_next_set: issue=%b a=%0d d=%0d required 1/11/14", issue2, a2, d2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_flush();
    test_reset_mid();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
